fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC, IF/ID register and end-of-memory halt
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter int unsigned MEM_BYTES = 24,
  parameter logic [31:0] NOP       = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] br_target,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic        EnIW,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halted,
  output logic [15:0] fetch_cnt
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  // 33-bit compare so a PC near the top of the address space cannot wrap into legality
  function automatic logic fetch_legal(input logic [31:0] addr);
    fetch_legal = ({1'b0, addr} + 33'd4) <= 33'(MEM_BYTES);
  endfunction

  localparam state_t RESET_STATE = fetch_legal(RESET_PC) ? RUN : HALT;

  state_t      state, state_nxt;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] tgt_aligned;
  logic        accept;

  assign pc_plus4    = pc_q + 32'd4;
  assign tgt_aligned = br_target & 32'hFFFF_FFFC;
  assign accept      = (state == RUN) && !stall && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = fetch_legal(tgt_aligned) ? RUN : HALT;
    end else if (!stall && state == RUN) begin
      state_nxt = fetch_legal(pc_plus4) ? RUN : HALT;
    end
  end

  always_comb begin
    pc     = pc_q;
    EnIW   = (state == RUN);
    halted = (state == HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      ifid_instr <= NOP;
      ifid_pc4   <= 32'd0;
      ifid_valid <= 1'b0;
      fetch_cnt  <= 16'd0;
    end else if (flush) begin
      pc_q       <= tgt_aligned;
      ifid_instr <= NOP;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      if (accept) begin
        pc_q       <= pc_plus4;
        ifid_instr <= instr_in;
        ifid_pc4   <= pc_plus4;
        ifid_valid <= 1'b1;
        if (fetch_cnt != 16'hFFFF) begin
          fetch_cnt <= fetch_cnt + 16'd1;
        end
      end else begin
        // halted: push one bubble so the last real instruction is seen only once
        ifid_instr <= NOP;
        ifid_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against a reference model
module tb_fetch_unit;

  localparam int          MEMB = 20;
  localparam logic [31:0] NOPV = 32'h00000000;
  localparam logic [7:0]  ROM [0:MEMB-1] = '{
    8'h01, 8'h23, 8'h00, 8'h00,
    8'h14, 8'h10, 8'hcb, 8'hed,
    8'h37, 8'h65, 8'h00, 8'h00,
    8'h78, 8'h70, 8'h00, 8'h05,
    8'hfa, 8'h89, 8'h00, 8'h00
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic [31:0] instr_in;
  logic [31:0] pc;
  logic        en_iw;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_halted;
  int          m_cnt;

  fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(MEMB), .NOP(NOPV)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .br_target(br_target),
    .instr_in(instr_in), .pc(pc), .EnIW(en_iw), .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid), .halted(halted), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    if (longint'(a) + 4 <= MEMB)
      return {ROM[a], ROM[a+1], ROM[a+2], ROM[a+3]};
    return 32'hdeadbeef;
  endfunction

  assign instr_in = fetch_word(pc);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("pc", pc, m_pc);
    check("EnIW", {31'd0, en_iw}, {31'd0, !m_halted});
    check("halted", {31'd0, halted}, {31'd0, m_halted});
    check("ifid_instr", ifid_instr, m_instr);
    check("ifid_pc4", ifid_pc4, m_pc4);
    check("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    check("fetch_cnt", {16'd0, fetch_cnt}, m_cnt);
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_instr = NOPV; m_pc4 = 32'd0; m_valid = 1'b0; m_cnt = 0;
    m_halted = (4 > MEMB);
  endtask

  task automatic do_cycle(input logic s, input logic f, input logic [31:0] t);
    logic [31:0] a;
    stall = s; flush = f; br_target = t;
    if (f) begin
      a = t & 32'hFFFF_FFFC;
      m_pc = a; m_instr = NOPV; m_valid = 1'b0;
      m_halted = (longint'(a) + 4 > MEMB);
    end else if (!s) begin
      if (!m_halted) begin
        m_instr = fetch_word(m_pc);
        m_pc = m_pc + 32'd4;
        m_pc4 = m_pc;
        m_valid = 1'b1;
        if (m_cnt < 65535) m_cnt++;
        m_halted = (longint'(m_pc) + 4 > MEMB);
      end else begin
        m_instr = NOPV; m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    stall = 1'b0; flush = 1'b0;
    check_all();
  endtask

  task automatic async_reset_pulse();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_pc", pc, 32'd0);
    check("async_valid", {31'd0, ifid_valid}, 32'd0);
    check("async_cnt", {16'd0, fetch_cnt}, 32'd0);
    check_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_w [0:4];
    exp_w = '{32'h01230000, 32'h1410cbed, 32'h37650000, 32'h78700005, 32'hfa890000};
    model_reset();
    #12;
    check_all();
    #1 rst = 1'b0;

    // straight line to the end of memory
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b0, 1'b0, 32'd0);
      check("line_instr", ifid_instr, exp_w[i]);
    end
    check("line_halted", {31'd0, halted}, 32'd1);
    do_cycle(1'b0, 1'b0, 32'd0);
    check("line_drain_valid", {31'd0, ifid_valid}, 32'd0);
    check("line_cnt", {16'd0, fetch_cnt}, 32'd5);

    // redirect to 0, fetch once, then reset between edges
    do_cycle(1'b0, 1'b1, 32'd0);
    do_cycle(1'b0, 1'b0, 32'd0);
    async_reset_pulse();

    // stall at pc=0x08
    do_cycle(1'b0, 1'b0, 32'd0);
    do_cycle(1'b0, 1'b0, 32'd0);
    check("pre_stall_pc", pc, 32'h08);
    for (int i = 0; i < 2; i++) begin
      do_cycle(1'b1, 1'b0, 32'd0);
      check("stall_pc", pc, 32'h08);
      check("stall_instr", ifid_instr, 32'h1410cbed);
      check("stall_cnt", {16'd0, fetch_cnt}, 32'd2);
    end
    do_cycle(1'b0, 1'b0, 32'd0);
    check("resume_instr", ifid_instr, 32'h37650000);

    // flush beats stall, misaligned target
    do_cycle(1'b1, 1'b1, 32'h0e);
    check("fs_pc", pc, 32'h0c);
    check("fs_valid", {31'd0, ifid_valid}, 32'd0);
    check("fs_instr", ifid_instr, NOPV);
    do_cycle(1'b0, 1'b0, 32'd0);
    check("fs_next", ifid_instr, 32'h78700005);

    // run into HALT, then redirect out of it
    do_cycle(1'b0, 1'b0, 32'd0);
    check("halt_again", {31'd0, halted}, 32'd1);
    do_cycle(1'b0, 1'b0, 32'd0);
    do_cycle(1'b0, 1'b1, 32'h04);
    check("redir_halted", {31'd0, halted}, 32'd0);
    check("redir_pc", pc, 32'h04);
    do_cycle(1'b0, 1'b0, 32'd0);
    check("redir_instr", ifid_instr, 32'h1410cbed);

    // illegal target
    do_cycle(1'b0, 1'b1, 32'h40);
    check("ill_halted", {31'd0, halted}, 32'd1);
    check("ill_eniw", {31'd0, en_iw}, 32'd0);
    check("ill_cnt", {16'd0, fetch_cnt}, 32'd6);

    // randomized mix of stall, flush and targets
    for (int i = 0; i < 400; i++) begin
      logic s, f;
      logic [31:0] t;
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 5) == 0);
      t = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 31));
      do_cycle(s, f, t);
      if ($urandom_range(0, 99) == 0) async_reset_pulse();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
